// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Purpose  : Multicycle control FSM for an RV32I subset core (lw, sw, R-type,
//            I-ALU, jal, beq). Steps each instruction through its cycles.
//            Drives the datapath mux selects, write enables and the 3-bit
//            ALU operation. Resolves beq from the ALU zero flag.
// Ports    : clk_i, rst_ni             clock, async active-low reset
//            op_i, funct3_i, funct7b5_i instruction fields from the IR
//            zero_i                    ALU zero flag
//            alu_ctrl_o                000 nop, 001 AND, 010 OR, 011 add, 100 sub
//            alu_src_a_o, alu_src_b_o  ALU operand selects
//            result_src_o, imm_src_o   result mux / immediate format
//            adr_src_o                 memory address select
//            ir_write_o, pc_write_o, reg_write_o, mem_write_o  write enables
//            illegal_o                 unsupported opcode / funct3 pulse
//            state_o                   current state (debug)
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [6:0]         op_i,
  input  logic [2:0]         funct3_i,
  input  logic               funct7b5_i,
  input  logic               zero_i,
  output logic [2:0]         alu_ctrl_o,
  output logic [1:0]         alu_src_a_o,
  output logic [1:0]         alu_src_b_o,
  output logic [1:0]         result_src_o,
  output logic [1:0]         imm_src_o,
  output logic               adr_src_o,
  output logic               ir_write_o,
  output logic               pc_write_o,
  output logic               reg_write_o,
  output logic               mem_write_o,
  output logic               illegal_o,
  output logic [STATE_W-1:0] state_o
);

  localparam logic [6:0] c_OP_LW   = 7'b0000011;
  localparam logic [6:0] c_OP_SW   = 7'b0100011;
  localparam logic [6:0] c_OP_R    = 7'b0110011;
  localparam logic [6:0] c_OP_I    = 7'b0010011;
  localparam logic [6:0] c_OP_JAL  = 7'b1101111;
  localparam logic [6:0] c_OP_BEQ  = 7'b1100011;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = STATE_W'(0),
    S_DECODE   = STATE_W'(1),
    S_MEMADR   = STATE_W'(2),
    S_MEMREAD  = STATE_W'(3),
    S_MEMWB    = STATE_W'(4),
    S_MEMWRITE = STATE_W'(5),
    S_EXECR    = STATE_W'(6),
    S_ALUWB    = STATE_W'(7),
    S_EXECI    = STATE_W'(8),
    S_JAL      = STATE_W'(9),
    S_BEQ      = STATE_W'(10)
  } state_t;

  // State-only (Moore) control bits, registered alongside the state.
  typedef struct packed {
    logic [2:0] alu;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] result_src;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_write;
  } ctrl_t;

  state_t r_state;
  state_t w_next;
  ctrl_t  r_ctrl;
  logic   w_is_exec;
  logic   w_op_legal;
  logic   w_fd_bad;
  logic [2:0] w_fd_alu;

  function automatic ctrl_t f_moore(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write = 1'b1; c.src_b = 2'b10; c.alu = 3'b011;
        c.result_src = 2'b10; c.pc_write = 1'b1;
      end
      S_DECODE:   begin c.src_a = 2'b01; c.src_b = 2'b01; c.alu = 3'b011; end
      S_MEMADR:   begin c.src_a = 2'b10; c.src_b = 2'b01; c.alu = 3'b011; end
      S_MEMREAD:  c.adr_src = 1'b1;
      S_MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
      S_MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
      S_EXECR:    c.src_a = 2'b10;
      S_EXECI:    begin c.src_a = 2'b10; c.src_b = 2'b01; end
      S_ALUWB:    c.reg_write = 1'b1;
      S_JAL: begin
        c.src_a = 2'b01; c.src_b = 2'b10; c.alu = 3'b011; c.pc_write = 1'b1;
      end
      // pc_write in BEQ comes from zero_i combinationally, not from here.
      S_BEQ:      begin c.src_a = 2'b10; c.alu = 3'b100; end
      default:    c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    w_op_legal = (op_i == c_OP_LW) || (op_i == c_OP_SW) || (op_i == c_OP_R) ||
                 (op_i == c_OP_I)  || (op_i == c_OP_JAL) || (op_i == c_OP_BEQ);
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH: w_next = S_DECODE;
      S_DECODE: begin
        case (op_i)
          c_OP_LW, c_OP_SW: w_next = S_MEMADR;
          c_OP_R:           w_next = S_EXECR;
          c_OP_I:           w_next = S_EXECI;
          c_OP_JAL:         w_next = S_JAL;
          c_OP_BEQ:         w_next = S_BEQ;
          default:          w_next = S_FETCH;
        endcase
      end
      S_MEMADR:                 w_next = (op_i == c_OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:                w_next = S_MEMWB;
      S_EXECR, S_EXECI, S_JAL:  w_next = S_ALUWB;
      default:                  w_next = S_FETCH;  // includes unused codes
    endcase
  end

  // Outputs are computed from the next state so they line up with r_state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_FETCH;
      r_ctrl  <= f_moore(S_FETCH);
    end else begin
      r_state <= w_next;
      r_ctrl  <= f_moore(w_next);
    end
  end

  // funct decode; subtraction only exists for register-register ops.
  always_comb begin
    w_fd_alu = 3'b000;
    w_fd_bad = 1'b0;
    case (funct3_i)
      3'b000:  w_fd_alu = ((r_state == S_EXECR) && funct7b5_i) ? 3'b100 : 3'b011;
      3'b110:  w_fd_alu = 3'b010;
      3'b111:  w_fd_alu = 3'b001;
      default: w_fd_bad = 1'b1;
    endcase
  end

  always_comb begin
    imm_src_o = 2'b00;
    case (op_i)
      c_OP_SW:  imm_src_o = 2'b01;
      c_OP_BEQ: imm_src_o = 2'b10;
      c_OP_JAL: imm_src_o = 2'b11;
      default:  imm_src_o = 2'b00;
    endcase
  end

  assign w_is_exec    = (r_state == S_EXECR) || (r_state == S_EXECI);
  assign alu_ctrl_o   = w_is_exec ? w_fd_alu : r_ctrl.alu;
  assign alu_src_a_o  = r_ctrl.src_a;
  assign alu_src_b_o  = r_ctrl.src_b;
  assign result_src_o = r_ctrl.result_src;
  assign adr_src_o    = r_ctrl.adr_src;

  // Enables are gated by rst_ni so none can assert while reset is held,
  // even though the registers already show FETCH values.
  assign ir_write_o  = rst_ni & r_ctrl.ir_write;
  assign pc_write_o  = rst_ni & (r_ctrl.pc_write | ((r_state == S_BEQ) & zero_i));
  assign reg_write_o = rst_ni & r_ctrl.reg_write;
  assign mem_write_o = rst_ni & r_ctrl.mem_write;
  assign illegal_o   = rst_ni & (((r_state == S_DECODE) & ~w_op_legal) |
                                 (w_is_exec & w_fd_bad));
  assign state_o     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl
// Purpose  : Scoreboard bench for multicycle_ctrl. The stimulus side pushes
//            one expected output set per clock cycle. A negedge monitor pops
//            and compares against the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] alu;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] rs;
    logic [1:0] imm;
    logic       adr;
    logic       irw;
    logic       pcw;
    logic       rw;
    logic       mw;
    logic       ill;
  } exp_t;

  typedef struct {
    exp_t e;
    int   tag;
    int   cyc;
  } sb_t;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [6:0] op_i;
  logic [2:0] funct3_i;
  logic       funct7b5_i;
  logic       zero_i;
  logic [2:0] alu_ctrl_o;
  logic [1:0] alu_src_a_o, alu_src_b_o, result_src_o, imm_src_o;
  logic       adr_src_o, ir_write_o, pc_write_o, reg_write_o, mem_write_o, illegal_o;
  logic [3:0] state_o;

  sb_t q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  multicycle_ctrl #(.STATE_W(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .op_i(op_i), .funct3_i(funct3_i),
    .funct7b5_i(funct7b5_i), .zero_i(zero_i), .alu_ctrl_o(alu_ctrl_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
    .result_src_o(result_src_o), .imm_src_o(imm_src_o), .adr_src_o(adr_src_o),
    .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .reg_write_o(reg_write_o),
    .mem_write_o(mem_write_o), .illegal_o(illegal_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic bit is_legal(input logic [6:0] op);
    return op inside {7'b0000011, 7'b0100011, 7'b0110011,
                      7'b0010011, 7'b1101111, 7'b1100011};
  endfunction

  // Sequence of states an instruction walks through, by instruction class.
  function automatic void state_seq(input logic [6:0] op, output int s[$]);
    case (op)
      7'b0000011: s = '{0, 1, 2, 3, 4};
      7'b0100011: s = '{0, 1, 2, 5};
      7'b0110011: s = '{0, 1, 6, 7};
      7'b0010011: s = '{0, 1, 8, 7};
      7'b1101111: s = '{0, 1, 9, 7};
      7'b1100011: s = '{0, 1, 10};
      default:    s = '{0, 1};
    endcase
  endfunction

  // Expected outputs for one cycle spent in state st.
  function automatic exp_t model(input int st, input logic [6:0] op,
                                 input logic [2:0] f3, input logic f7,
                                 input logic z, input bit in_reset);
    exp_t e;
    logic bad;
    logic [2:0] fa;
    e = '0;
    e.st = 4'(st);
    e.imm = (op == 7'b0100011) ? 2'b01 : (op == 7'b1100011) ? 2'b10 :
            (op == 7'b1101111) ? 2'b11 : 2'b00;
    bad = !(f3 inside {3'b000, 3'b110, 3'b111});
    fa  = (f3 == 3'b110) ? 3'd2 : (f3 == 3'b111) ? 3'd1 :
          (f3 == 3'b000) ? ((st == 6 && f7) ? 3'd4 : 3'd3) : 3'd0;
    case (st)
      0:  begin e.irw = 1; e.sb = 2; e.alu = 3; e.rs = 2; e.pcw = 1; end
      1:  begin e.sa = 1; e.sb = 1; e.alu = 3; e.ill = !is_legal(op); end
      2:  begin e.sa = 2; e.sb = 1; e.alu = 3; end
      3:  e.adr = 1;
      4:  begin e.rs = 1; e.rw = 1; end
      5:  begin e.adr = 1; e.mw = 1; end
      6:  begin e.sa = 2; e.sb = 0; e.alu = fa; e.ill = bad; end
      7:  e.rw = 1;
      8:  begin e.sa = 2; e.sb = 1; e.alu = fa; e.ill = bad; end
      9:  begin e.sa = 1; e.sb = 2; e.alu = 3; e.pcw = 1; end
      10: begin e.sa = 2; e.alu = 4; e.pcw = z; end
      default: ;
    endcase
    if (in_reset) begin
      e.irw = 0; e.pcw = 0; e.rw = 0; e.mw = 0; e.ill = 0;
    end
    return e;
  endfunction

  function automatic void push(input exp_t e, input int tag, input int cyc);
    sb_t s;
    s.e = e; s.tag = tag; s.cyc = cyc;
    q.push_back(s);
  endfunction

  // Monitor: samples away from the active edge.
  always @(negedge clk_i) begin
    if (q.size() > 0) begin
      sb_t  s;
      exp_t a;
      s = q.pop_front();
      a = '{st: state_o, alu: alu_ctrl_o, sa: alu_src_a_o, sb: alu_src_b_o,
            rs: result_src_o, imm: imm_src_o, adr: adr_src_o, irw: ir_write_o,
            pcw: pc_write_o, rw: reg_write_o, mw: mem_write_o, ill: illegal_o};
      n_tests++;
      if (a !== s.e) begin
        n_fail++;
        $display("FAIL instr%0d_cyc%0d: got st=%0d alu=%b sa=%b sb=%b rs=%b imm=%b adr=%b irw=%b pcw=%b rw=%b mw=%b ill=%b ; want st=%0d alu=%b sa=%b sb=%b rs=%b imm=%b adr=%b irw=%b pcw=%b rw=%b mw=%b ill=%b",
                 s.tag, s.cyc, a.st, a.alu, a.sa, a.sb, a.rs, a.imm, a.adr, a.irw, a.pcw, a.rw, a.mw, a.ill,
                 s.e.st, s.e.alu, s.e.sa, s.e.sb, s.e.rs, s.e.imm, s.e.adr, s.e.irw, s.e.pcw, s.e.rw, s.e.mw, s.e.ill);
      end
    end
  end

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic z, input int tag);
    int s[$];
    op_i = op; funct3_i = f3; funct7b5_i = f7; zero_i = z;
    state_seq(op, s);
    foreach (s[k]) push(model(s[k], op, f3, f7, z, 0), tag, k);
    repeat (s.size()) @(posedge clk_i);
    #1;
  endtask

  localparam logic [6:0] c_OPS [6] = '{7'b0000011, 7'b0100011, 7'b0110011,
                                        7'b0010011, 7'b1101111, 7'b1100011};

  initial begin
    logic [6:0] rop;
    rst_ni = 1'b0; op_i = 7'b0000011; funct3_i = 3'b010; funct7b5_i = 0; zero_i = 0;
    @(posedge clk_i); #1;
    for (int k = 0; k < 3; k++) push(model(0, op_i, funct3_i, 0, 0, 1), 0, k);
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 1);  // lw
    run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 2);  // sub
    run_instr(7'b0010011, 3'b000, 1'b1, 1'b0, 3);  // addi, no sub
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 4);  // beq taken
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 5);  // beq not taken
    run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 6);  // illegal opcode
    run_instr(7'b0110011, 3'b001, 1'b0, 1'b0, 7);  // illegal funct3
    run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 8);  // jal
    run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 9);  // sw

    // sw interrupted by asynchronous reset during MEMADR
    op_i = 7'b0100011; funct3_i = 3'b010; funct7b5_i = 0; zero_i = 0;
    push(model(0, op_i, funct3_i, 0, 0, 0), 10, 0);
    push(model(1, op_i, funct3_i, 0, 0, 0), 10, 1);
    repeat (2) @(posedge clk_i);
    #1;
    push(model(0, op_i, funct3_i, 0, 0, 1), 10, 2);
    #2 rst_ni = 1'b0;
    #1;
    n_tests++;
    if (state_o !== 4'd0 || mem_write_o !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got state=%0d mem_write=%b, want state=0 mem_write=0",
               state_o, mem_write_o);
    end
    @(posedge clk_i); #1;
    push(model(0, op_i, funct3_i, 0, 0, 1), 10, 3);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    for (int t = 0; t < 250; t++) begin
      if ($urandom_range(0, 3) == 0) rop = 7'($urandom);
      else                           rop = c_OPS[$urandom_range(0, 5)];
      run_instr(rop, 3'($urandom), 1'($urandom), 1'($urandom), 100 + t);
    end

    @(negedge clk_i);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle control FSM for the RV32I subset core.
- Issues per-cycle datapath selects and write enables, and produces the 3-bit ALU operation code consumed by the datapath ALU.
- Consumes the ALU zero flag to resolve beq.
- Sits between the instruction register and the datapath muxes.

Parameters:
- STATE_W, 4, width of the state register and the state_o debug port.

Ports:
- clk_i  in  1  core clock; all state updates on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- op_i  in  7  instruction[6:0] from the instruction register
- funct3_i  in  3  instruction[14:12]
- funct7b5_i  in  1  instruction[30]
- zero_i  in  1  ALU zero flag (1 when ALU result == 0)
- alu_ctrl_o  out  3  ALU operation: 000 no-op, 001 AND, 010 OR, 011 add, 100 sub
- alu_src_a_o  out  2  operand A select: 00 PC, 01 oldPC, 10 rs1
- alu_src_b_o  out  2  operand B select: 00 rs2, 01 immediate, 10 constant 4
- result_src_o  out  2  result select: 00 ALUOut register, 01 memory data, 10 ALU result direct
- imm_src_o  out  2  immediate format: 00 I, 01 S, 10 B, 11 J
- adr_src_o  out  1  memory address select: 0 PC, 1 result
- ir_write_o  out  1  load instruction register
- pc_write_o  out  1  load PC
- reg_write_o  out  1  register file write
- mem_write_o  out  1  data memory write
- illegal_o  out  1  one-cycle pulse on an unsupported opcode or funct3
- state_o  out  STATE_W  current state (debug)

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10. Codes 11–15 are unused and return to FETCH on the next edge.
- Reset (rst_ni low, asynchronous): state=FETCH.
  - ir_write_o, pc_write_o, reg_write_o, mem_write_o and illegal_o are forced 0 while rst_ni is low.
  - All other outputs show FETCH values.
- Transitions:
  - FETCH -> DECODE.
  - DECODE -> by op_i:
    - 0000011 (lw) or 0100011 (sw) -> MEMADR
    - 0110011 (R-type) -> EXECUTER
    - 0010011 (I-ALU) -> EXECUTEI
    - 1101111 (jal) -> JAL
    - 1100011 (beq) -> BEQ
    - anything else -> FETCH
  - MEMADR -> MEMREAD if lw, MEMWRITE if sw.
  - MEMREAD -> MEMWB.
  - EXECUTER, EXECUTEI, JAL -> ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BEQ -> FETCH.
- Moore outputs. Each state drives only the outputs listed; every other output is 0.
  - FETCH: adr_src 0, ir_write 1, src_a 00, src_b 10, alu_ctrl 011, result_src 10, pc_write 1.
  - DECODE: src_a 01, src_b 01, alu_ctrl 011 (branch target into ALUOut).
  - MEMADR: src_a 10, src_b 01, alu_ctrl 011.
  - MEMREAD: result_src 00, adr_src 1.
  - MEMWB: result_src 01, reg_write 1.
  - MEMWRITE: result_src 00, adr_src 1, mem_write 1.
  - EXECUTER: src_a 10, src_b 00, alu_ctrl = funct decode.
  - EXECUTEI: src_a 10, src_b 01, alu_ctrl = funct decode with sub disabled.
  - ALUWB: result_src 00, reg_write 1.
  - JAL: src_a 01, src_b 10, alu_ctrl 011, result_src 00, pc_write 1.
  - BEQ: src_a 10, src_b 00, alu_ctrl 100, result_src 00, pc_write = zero_i. This is the only combinational output; it has no registered delay.
- Funct decode:
  - funct3 000 -> 100 if (EXECUTER and funct7b5_i), else 011.
  - funct3 110 -> 010.
  - funct3 111 -> 001.
  - Any other funct3 -> 000, and illegal_o=1 for that execute cycle. The FSM still proceeds to ALUWB.
- imm_src_o is decoded from op_i in every state: lw/I-ALU 00, sw 01, beq 10, jal 11, others 00.
- illegal_o is also 1 in DECODE when op_i is unsupported; the next state is then FETCH and no write enable asserts.
- Instruction latency in cycles: lw 5, sw 4, R/I 4, jal 4, beq 3, illegal 2.
- Reset mid-instruction: the FSM returns to FETCH immediately. No partial write enable may assert after rst_ni falls.

Test Plan:
- Reset held low for 3 cycles, then released -> state_o=0 and all write enables 0 during reset; first edge after release shows ir_write=1, pc_write=1, alu_ctrl=011.
- lw (op 0000011, funct3 010) -> state sequence 0,1,2,3,4,0; reg_write=1 only in state 4 with result_src=01; adr_src=1 in state 3.
- R-type sub (op 0110011, funct3 000, funct7b5=1) -> EXECUTER alu_ctrl=100; addi (op 0010011, funct3 000, funct7b5=1) -> EXECUTEI alu_ctrl=011.
- beq with zero_i=1 -> pc_write=1 in BEQ; repeat with zero_i=0 -> pc_write=0; both return to FETCH after 3 cycles.
- Illegal op 1111111 -> illegal_o pulses in DECODE, next state FETCH, no reg_write or mem_write; R-type funct3 001 -> alu_ctrl=000 and illegal_o=1 in EXECUTER.
- sw, with rst_ni dropped asynchronously mid-MEMADR -> state_o=0 immediately and mem_write never asserted.
